char_line_render: RTL and testbench
===================================

CHAR_LINE_RENDER -- requirements
Module: char_line_render

Interface
REQ-001 Parameter X0, default 64: left pixel column of the text window.
REQ-002 Parameter Y0, default 32: top pixel row of the text window.
REQ-003 Parameter FG_RGB, default 12'hFFF: colour of a lit glyph pixel.
REQ-004 Parameter BG_RGB, default 12'h000: colour of an unlit pixel, inside or outside the window.
REQ-005 clk  in  1  single system clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 video_on  in  1  high while x/y lie in the visible area.
REQ-008 x  in  10  current pixel column from the sync generator.
REQ-009 y  in  10  current pixel row from the sync generator.
REQ-010 wr_en  in  1  write strobe for the character buffer.
REQ-011 wr_addr  in  5  character buffer cell index, 0..31.
REQ-012 wr_char  in  7  ASCII code to store.
REQ-013 cursor_en  in  1  enables the blinking cursor.
REQ-014 cursor_pos  in  5  cell index that carries the cursor.
REQ-015 frame_tick  in  1  one-cycle pulse, once per frame.
REQ-016 rom_addr  out  11  glyph ROM address, {code[6:0], row[3:0]}.
REQ-017 rom_data  in  8  glyph ROM row pattern; MSB is the leftmost pixel; valid one clk after rom_addr.
REQ-018 pixel_on  out  1  glyph pixel lit after cursor inversion.
REQ-019 rgb  out  12  FG_RGB when pixel_on=1, else BG_RGB.

Function
REQ-020 Buffer SHALL hold 32 cells of 7 bits; wr_en=1 SHALL write wr_char to cell wr_addr on the clock edge.
REQ-021 A same-cycle read and write of one cell SHALL return the old value (read-before-write).
REQ-022 Window SHALL be X0 <= x < X0+8*32 and Y0 <= y < Y0+16, with video_on=1; comparisons are made before subtraction, so no wrap-around.
REQ-023 Inside the window: cell = (x-X0)>>3, col = (x-X0)[2:0], row = (y-Y0)[3:0].
REQ-024 Stage 1 (edge 1) SHALL register the cell code, row, col, cell index and in_window.
REQ-025 rom_addr SHALL be driven from stage 1 registers only; when in_window=0 it SHALL be 11'h200 (space glyph).
REQ-026 Stage 2 (edge 2) SHALL register col, cell index and in_window while the ROM latches rom_addr.
REQ-027 Stage 3 (edge 3) SHALL register pixel_on = in_window2 & (rom_data[7-col2] XOR cursor_hit).
REQ-028 pixel_on and rgb SHALL reflect x/y sampled exactly 3 edges earlier.
REQ-029 A 5-bit frame counter SHALL increment on each frame_tick and wrap 31->0.
REQ-030 cursor_hit SHALL equal cursor_en & counter[4] & (cell2 == cursor_pos) & in_window2.
REQ-031 A 1-cycle-late frame_tick coinciding with window pixels SHALL take effect on the next pipeline entry only; no glitch within a pixel.

Reset
REQ-032 While reset=1: all pipeline registers, pixel_on and the frame counter SHALL be 0, rgb SHALL be BG_RGB, rom_addr SHALL be 11'h200, and every buffer cell SHALL be 7'h20.
REQ-033 Reset asserted mid-line SHALL blank output immediately (asynchronous); the first valid pixel SHALL appear 3 edges after release.

Configuration
REQ-034 With TEXT_SCALE2_EN defined, glyphs SHALL be 16x32: window is 16*32 wide by 32 tall, cell = (x-X0)>>4, col = (x-X0)[3:1], row = (y-Y0)[4:1]; latency is unchanged.
REQ-035 With TEXT_SCALE2_EN undefined, REQ-022 and REQ-023 SHALL apply as written.

Verification
REQ-036 Write 0x35 to cell 0, then sweep y=34, x=64..71 -> rom_addr=0x352 one edge later; pixel_on=1 for x 64..70 and 0 for x=71, each 3 edges after its x.
REQ-037 Apply x=63 or y=31, or video_on=0 -> pixel_on=0, rgb=12'h000, rom_addr=0x200.
REQ-038 Write 0x31 to cell 31 while reading cell 31 in the same cycle -> the old code (0x20) is seen; 0x31 is seen on the next read.
REQ-039 cursor_en=1, cursor_pos=0, send 16 frame_ticks, then render an empty cell 0 at y=32 -> pixel_on=1 for all 8 columns; after 16 more ticks -> 0.
REQ-040 Assert reset during x=66 -> pixel_on=0 at once, all cells read 0x20, frame counter 0.
REQ-041 TEXT_SCALE2_EN defined, cell 0=0x30, y=36 (row 2), x=64..79 -> pixel pairs follow 00111000, i.e. x=68..73 lit.

Source files
------------

// File: rtl/char_line_render_if.sv
// char_line_render_if
//   Groups the pixel-position, character-write, cursor, glyph-ROM and video
//   output signals of char_line_render into one bundle.
//   slave  : the renderer's view.
//            Inputs:  video_on, x, y, wr_en, wr_addr, wr_char, cursor_en,
//                     cursor_pos, frame_tick, rom_data.
//            Outputs: rom_addr, pixel_on, rgb.
//   master : the environment's view (sync generator, CPU, glyph ROM, display).
//   Timing contract: every input is sampled on the rising clk edge. There is
//   no valid/ready handshake. The pixel stream is a fixed-latency pipeline, and
//   rom_data must carry the ROM row for the rom_addr of the previous cycle.
interface char_line_render_if;
  logic        video_on;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [6:0]  wr_char;
  logic        cursor_en;
  logic [4:0]  cursor_pos;
  logic        frame_tick;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic        pixel_on;
  logic [11:0] rgb;

  modport slave (
    input  video_on, x, y, wr_en, wr_addr, wr_char,
    input  cursor_en, cursor_pos, frame_tick, rom_data,
    output rom_addr, pixel_on, rgb
  );

  modport master (
    output video_on, x, y, wr_en, wr_addr, wr_char,
    output cursor_en, cursor_pos, frame_tick, rom_data,
    input  rom_addr, pixel_on, rgb
  );
endinterface

// File: rtl/char_line_render.sv
// char_line_render
//   Renders a single line of 32 text cells into the video stream. The line
//   sits at pixel position (X0, Y0). A 32 x 7-bit character buffer supplies
//   the code for each cell. An external synchronous glyph ROM supplies the row
//   patterns. A blinking cursor inverts the glyph in one cell.
//   Ports:
//     clk   - system clock, rising edge.
//     reset - asynchronous, active-high reset.
//     bus   - char_line_render_if.slave. It carries video_on/x/y, the
//             wr_en/wr_addr/wr_char buffer write port, cursor_en/cursor_pos,
//             frame_tick, rom_addr/rom_data, pixel_on and rgb.
//   Pipeline: edge 1 registers the cell lookup and drives rom_addr. Edge 2 is
//   the ROM access. Edge 3 registers pixel_on. Output is therefore 3 edges
//   behind x/y.
//   Build option: define TEXT_SCALE2_EN for 16x32 pixel-doubled glyphs.
module char_line_render #(
  parameter int          X0     = 64,
  parameter int          Y0     = 32,
  parameter logic [11:0] FG_RGB = 12'hFFF,
  parameter logic [11:0] BG_RGB = 12'h000
) (
  input  logic             clk,
  input  logic             reset,
  char_line_render_if.slave bus
);

`ifdef TEXT_SCALE2_EN
  localparam int CELL_W = 16;
  localparam int CELL_H = 32;
`else
  localparam int CELL_W = 8;
  localparam int CELL_H = 16;
`endif
  localparam int WIN_W = CELL_W * 32;

  // Character buffer
  logic [6:0] mem_q [32];

  // Stage 1
  logic [6:0] s1_code_q;
  logic [3:0] s1_row_q;
  logic [2:0] s1_col_q;
  logic [4:0] s1_cell_q;
  logic       s1_win_q;

  // Stage 2
  logic [2:0] s2_col_q;
  logic [4:0] s2_cell_q;
  logic       s2_win_q;

  // Stage 3 and frame counter
  logic       pixel_q, pixel_d;
  logic [4:0] frame_cnt_q;

  logic       in_win_d;
  logic [9:0] x_rel, y_rel;
  logic [4:0] cell_d;
  logic [2:0] col_d;
  logic [3:0] row_d;
  logic       cursor_hit;
  logic       unused_rel;

  // The bounds are compared on the raw coordinates, before any subtraction.
  // Out-of-window positions therefore never alias into the window through
  // wrap-around.
  assign in_win_d = bus.video_on &&
                    (int'(bus.x) >= X0) && (int'(bus.x) < X0 + WIN_W) &&
                    (int'(bus.y) >= Y0) && (int'(bus.y) < Y0 + CELL_H);

  assign x_rel = bus.x - 10'(X0);
  assign y_rel = bus.y - 10'(Y0);

`ifdef TEXT_SCALE2_EN
  assign cell_d = x_rel[8:4];
  assign col_d  = x_rel[3:1];
  assign row_d  = y_rel[4:1];
`else
  assign cell_d = x_rel[7:3];
  assign col_d  = x_rel[2:0];
  assign row_d  = y_rel[3:0];
`endif
  assign unused_rel = ^{x_rel, y_rel};

  // Buffer write. Stage 1 reads mem_q on the same edge, so a same-cycle read
  // of the written cell returns the old code.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= 7'h20;
    end else if (bus.wr_en) begin
      mem_q[bus.wr_addr] <= bus.wr_char;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_code_q <= '0;
      s1_row_q  <= '0;
      s1_col_q  <= '0;
      s1_cell_q <= '0;
      s1_win_q  <= 1'b0;
      s2_col_q  <= '0;
      s2_cell_q <= '0;
      s2_win_q  <= 1'b0;
      pixel_q   <= 1'b0;
    end else begin
      s1_code_q <= mem_q[cell_d];
      s1_row_q  <= row_d;
      s1_col_q  <= col_d;
      s1_cell_q <= cell_d;
      s1_win_q  <= in_win_d;
      s2_col_q  <= s1_col_q;
      s2_cell_q <= s1_cell_q;
      s2_win_q  <= s1_win_q;
      pixel_q   <= pixel_d;
    end
  end

  // Bit 4 of the frame counter sets the cursor blink rate: 16 frames on,
  // 16 frames off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_cnt_q <= '0;
    else if (bus.frame_tick) frame_cnt_q <= frame_cnt_q + 5'd1;
  end

  // Outside the window, the ROM is pointed at the space glyph.
  assign bus.rom_addr = s1_win_q ? {s1_code_q, s1_row_q} : 11'h200;

  always_comb begin
    cursor_hit = bus.cursor_en & frame_cnt_q[4] &
                 (s2_cell_q == bus.cursor_pos) & s2_win_q;
    pixel_d    = s2_win_q & (bus.rom_data[3'd7 - s2_col_q] ^ cursor_hit);
  end

  assign bus.pixel_on = pixel_q;
  assign bus.rgb      = pixel_q ? FG_RGB : BG_RGB;

endmodule

// File: tb/tb_char_line_render.sv
// tb_char_line_render
//   Directed bench for char_line_render. Each stimulus cycle may push an
//   expected rom_addr and/or pixel_on. A bench-side tag pipeline marks when
//   the DUT presents each result: rom_addr one edge later, pixel_on three
//   edges later. A monitor pops and compares at that point. The glyph ROM is
//   a small synchronous model holding hand-chosen row patterns.
module tb_char_line_render;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  char_line_render_if bus();

  char_line_render dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [10:0] exp_ra_q[$];
  logic [0:0]  exp_px_q[$];

  logic       stim_ra = 1'b0;
  logic       stim_px = 1'b0;
  logic       ra_tag  = 1'b0;
  logic [2:0] px_tag  = 3'b000;

  // Glyph ROM model: '5' row 2 = 11111110, '0' row 2 = 00111000, others blank.
  function automatic logic [7:0] rom_model(input logic [10:0] a);
    case (a)
      11'h352: return 8'hFE;
      11'h302: return 8'h38;
      default: return 8'h00;
    endcase
  endfunction

  initial bus.rom_data = 8'h00;
  always @(posedge clk) bus.rom_data <= rom_model(bus.rom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ra_tag <= 1'b0;
      px_tag <= 3'b000;
    end else begin
      ra_tag <= stim_ra;
      px_tag <= {px_tag[1:0], stim_px};
    end
  end

  // Monitor
  always @(posedge clk) begin
    logic [10:0] e_ra;
    logic [0:0]  e_px;
    #2;
    if (ra_tag) begin
      if (exp_ra_q.size() == 0) check("ra_queue_underflow", 1, 0);
      else begin
        e_ra = exp_ra_q.pop_front();
        check("rom_addr", 32'(bus.rom_addr), 32'(e_ra));
      end
    end
    if (px_tag[2]) begin
      if (exp_px_q.size() == 0) check("px_queue_underflow", 1, 0);
      else begin
        e_px = exp_px_q.pop_front();
        check("pixel_on", 32'(bus.pixel_on), 32'(e_px));
        check("rgb", 32'(bus.rgb), e_px[0] ? 32'hFFF : 32'h000);
      end
    end
  end

  // Called at a negedge; returns at the following negedge.
  task automatic drive(input int xx, input int yy, input bit von,
                       input bit c_ra, input logic [10:0] ra,
                       input bit c_px, input bit px);
    bus.x        = 10'(xx);
    bus.y        = 10'(yy);
    bus.video_on = von;
    stim_ra      = c_ra;
    stim_px      = c_px;
    if (c_ra) exp_ra_q.push_back(ra);
    if (c_px) exp_px_q.push_back(px);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 1'b0, 1'b0, 11'h0, 1'b0, 1'b0);
  endtask

  task automatic write_cell(input logic [4:0] a, input logic [6:0] c);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_char = c;
    idle(1);
    bus.wr_en   = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_tick = 1'b1;
      idle(1);
      bus.frame_tick = 1'b0;
      idle(1);
    end
  endtask

  initial begin
    bus.video_on   = 1'b0;
    bus.x          = '0;
    bus.y          = '0;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_char    = '0;
    bus.cursor_en  = 1'b0;
    bus.cursor_pos = '0;
    bus.frame_tick = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_pixel_on", 32'(bus.pixel_on), 0);
    check("reset_rgb", 32'(bus.rgb), 32'h000);
    check("reset_rom_addr", 32'(bus.rom_addr), 32'h200);
    rst = 1'b0;
    idle(2);

`ifdef TEXT_SCALE2_EN
    write_cell(5'd0, 7'h30);
    for (int xx = 64; xx < 80; xx++)
      drive(xx, 36, 1'b1, 1'b1, 11'h302, 1'b1, (xx >= 68 && xx <= 73));
    drive(63, 36, 1'b1, 1'b1, 11'h200, 1'b1, 1'b0);
    drive(64 + 512, 36, 1'b1, 1'b1, 11'h200, 1'b1, 1'b0);
    drive(64, 64, 1'b1, 1'b1, 11'h200, 1'b1, 1'b0);
    idle(5);
`else
    // Glyph '5' row 2 in cell 0
    write_cell(5'd0, 7'h35);
    for (int xx = 64; xx < 72; xx++)
      drive(xx, 34, 1'b1, 1'b1, 11'h352, 1'b1, (xx != 71));

    // Window boundaries
    drive(63, 34, 1'b1, 1'b1, 11'h200, 1'b1, 1'b0);
    drive(64, 31, 1'b1, 1'b1, 11'h200, 1'b1, 1'b0);
    drive(64, 34, 1'b0, 1'b1, 11'h200, 1'b1, 1'b0);
    drive(320, 34, 1'b1, 1'b1, 11'h200, 1'b1, 1'b0);
    drive(64, 48, 1'b1, 1'b1, 11'h200, 1'b1, 1'b0);
    drive(319, 47, 1'b1, 1'b1, 11'h20F, 1'b1, 1'b0);

    // Same-cycle write and read of cell 31: old code first, new code next
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd31;
    bus.wr_char = 7'h31;
    drive(312, 33, 1'b1, 1'b1, 11'h201, 1'b0, 1'b0);
    bus.wr_en   = 1'b0;
    drive(312, 33, 1'b1, 1'b1, 11'h311, 1'b0, 1'b0);
    idle(4);

    // Cursor on an empty cell 0 after 16 frames
    write_cell(5'd0, 7'h20);
    bus.cursor_en  = 1'b1;
    bus.cursor_pos = 5'd0;
    ticks(16);
    for (int xx = 64; xx < 72; xx++)
      drive(xx, 32, 1'b1, 1'b1, 11'h200, 1'b1, 1'b1);
    drive(72, 32, 1'b1, 1'b0, 11'h0, 1'b1, 1'b0);
    idle(4);

    // Asynchronous reset mid-line, while lit cursor pixels are in flight
    drive(64, 32, 1'b1, 1'b0, 11'h0, 1'b0, 1'b0);
    drive(65, 32, 1'b1, 1'b0, 11'h0, 1'b0, 1'b0);
    drive(66, 32, 1'b1, 1'b0, 11'h0, 1'b0, 1'b0);
    drive(67, 32, 1'b1, 1'b0, 11'h0, 1'b0, 1'b0);
    bus.x = 10'd66;
    #1 rst = 1'b1;
    #1;
    check("async_reset_pixel_on", 32'(bus.pixel_on), 0);
    check("async_reset_rgb", 32'(bus.rgb), 32'h000);
    check("async_reset_rom_addr", 32'(bus.rom_addr), 32'h200);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    // Buffer back to spaces, counter back to 0 (cursor dark)
    drive(64, 33, 1'b1, 1'b1, 11'h201, 1'b1, 1'b0);
    drive(312, 33, 1'b1, 1'b1, 11'h201, 1'b1, 1'b0);
    idle(4);

    // Blink: on after 16 ticks, off after 16 more
    ticks(16);
    for (int xx = 64; xx < 68; xx++)
      drive(xx, 32, 1'b1, 1'b0, 11'h0, 1'b1, 1'b1);
    idle(4);
    ticks(16);
    for (int xx = 64; xx < 72; xx++)
      drive(xx, 32, 1'b1, 1'b0, 11'h0, 1'b1, 1'b0);
    idle(5);
`endif

    check("ra_queue_drained", 32'(exp_ra_q.size()), 0);
    check("px_queue_drained", 32'(exp_px_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
